// File: rtl/layer0_framer_pkg.sv
// Shared types and default geometry for the layer-0 input framer.
package layer0_framer_pkg;

   localparam int DEF_IN_BITS     = 2;
   localparam int DEF_FRAME_BEATS = 32;

   typedef enum logic [1:0] {
      ST_FILL    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_DISCARD = 2'd2
   } state_e;

endpackage : layer0_framer_pkg

// File: rtl/frame_hold_reg.sv
// Single-entry valid/ready output register holding one assembled input vector.
module frame_hold_reg #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   logic         valid_q;
   logic [W-1:0] data_q;

   // Accept a new vector when empty or when the held one drains this cycle.
   assign in_ready_o  = !valid_q || out_ready_i;
   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;

   // NOTE: the data register is reset too, because m_data must read zero during reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (in_valid_i && in_ready_o) begin
         valid_q <= 1'b1;
         data_q  <= in_data_i;
      end else if (out_ready_i) begin
         valid_q <= 1'b0;
      end
   end

endmodule : frame_hold_reg

// File: rtl/layer0_input_framer.sv
// Packs IN_BITS-wide stream beats into one FRAME_W vector for the layer-0 neuron array.
// Optional saturating malformed-frame counter enabled by LAYER0_FRAMER_ERRCNT_EN.
module layer0_input_framer
   import layer0_framer_pkg::*;
#(
   parameter int IN_BITS     = DEF_IN_BITS,
   parameter int FRAME_BEATS = DEF_FRAME_BEATS,
   parameter int FRAME_W     = IN_BITS * FRAME_BEATS
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [IN_BITS-1:0] s_data,
   input  logic               s_last,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [FRAME_W-1:0] m_data,
   output logic               frame_err,
   output logic [15:0]        err_cnt
);

   localparam int CNT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_BEATS - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [FRAME_W-1:0] asm_q, asm_d;
   logic               err_q, err_d;
   logic               ready_en_q;
   logic               accept;
   logic               push;
   logic               hold_ready;

   // Held low through reset and released on the first edge afterwards.
   assign s_ready = ready_en_q && (state_q != ST_WAIT);
   assign accept  = s_valid && s_ready;

   // NOTE: every combinational output gets a default first, so no path infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      asm_d   = asm_q;
      err_d   = 1'b0;
      push    = 1'b0;
      unique case (state_q)
         ST_FILL: begin
            if (accept) begin
               for (int k = 0; k < FRAME_BEATS; k++) begin
                  if (cnt_q == CNT_W'(k)) asm_d[k*IN_BITS +: IN_BITS] = s_data;
               end
               if (cnt_q == CNT_MAX) begin
                  cnt_d = '0;
                  if (s_last) begin
                     if (hold_ready) push = 1'b1;
                     else            state_d = ST_WAIT;
                  end else begin
                     err_d   = 1'b1;
                     state_d = ST_DISCARD;
                  end
               end else if (s_last) begin
                  cnt_d = '0;
                  err_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_WAIT: begin
            if (hold_ready) begin
               push    = 1'b1;
               state_d = ST_FILL;
            end
         end
         ST_DISCARD: begin
            if (accept && s_last) state_d = ST_FILL;
         end
         default: state_d = ST_FILL;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_FILL;
         cnt_q      <= '0;
         asm_q      <= '0;
         err_q      <= 1'b0;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         asm_q      <= asm_d;
         err_q      <= err_d;
         ready_en_q <= 1'b1;
      end
   end

   assign frame_err = err_q;

   frame_hold_reg #(.W(FRAME_W)) u_hold (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (push),
      .in_ready_o (hold_ready),
      .in_data_i  (asm_d),
      .out_valid_o(m_valid),
      .out_ready_i(m_ready),
      .out_data_o (m_data)
   );

`ifdef LAYER0_FRAMER_ERRCNT_EN
   logic [15:0] err_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              err_cnt_q <= '0;
      else if (err_q && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = '0;
`endif

endmodule : layer0_input_framer

// File: tb/tb_layer0_input_framer.sv
// Directed self-checking bench for layer0_input_framer with IN_BITS=2, FRAME_BEATS=4.
module tb_layer0_input_framer;

   localparam int IN_BITS     = 2;
   localparam int FRAME_BEATS = 4;
   localparam int FRAME_W     = 8;

`ifdef LAYER0_FRAMER_ERRCNT_EN
   localparam logic [15:0] EXP_ERRCNT = 16'd1;
`else
   localparam logic [15:0] EXP_ERRCNT = 16'd0;
`endif

   logic               clk = 1'b0;
   logic               rst_n;
   logic               s_valid;
   logic               s_ready;
   logic [IN_BITS-1:0] s_data;
   logic               s_last;
   logic               m_valid;
   logic               m_ready;
   logic [FRAME_W-1:0] m_data;
   logic               frame_err;
   logic [15:0]        err_cnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_err = 0;
   int stall = 0;
   logic [FRAME_W-1:0] out_q[$];
   int                 out_t[$];

   layer0_input_framer #(.IN_BITS(IN_BITS), .FRAME_BEATS(FRAME_BEATS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .s_last   (s_last),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .frame_err(frame_err),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Inputs change just after the rising edge, so the falling edge sees what the next edge will.
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_valid && m_ready) begin
            out_q.push_back(m_data);
            out_t.push_back(cyc);
         end
         if (frame_err) n_err++;
         if (s_valid && !s_ready) stall++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
   endtask

   task automatic send_beat(input logic [IN_BITS-1:0] d, input logic last);
      bit done = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (s_ready) begin
            @(posedge clk);
            #1;
            done = 1;
         end
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL beat_timeout: beat %b not accepted within 50 cycles", d);
      end
   endtask

   task automatic send_frame(input logic [FRAME_W-1:0] v);
      for (int k = 0; k < FRAME_BEATS; k++) begin
         logic [IN_BITS-1:0] b;
         b = v[k*IN_BITS +: IN_BITS];
         send_beat(b, k == FRAME_BEATS - 1);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst_n   = 1'b1;
      m_ready = 1'b0;
      idle();
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({s_ready, m_valid, m_data, frame_err, err_cnt} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got s_ready=%b m_valid=%b m_data=%h frame_err=%b err_cnt=%h want all 0",
                  s_ready, m_valid, m_data, frame_err, err_cnt);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if (s_ready !== 1'b0) begin
         bad++;
         $display("FAIL ready_before_edge: got %b want 0", s_ready);
      end
      step();
      total++;
      if (s_ready !== 1'b1) begin
         bad++;
         $display("FAIL ready_after_edge: got %b want 1", s_ready);
      end
   endtask

   task automatic test_basic();
      m_ready = 1'b1;
      out_q.delete();
      send_frame(8'h39);
      idle();
      total++;
      if (m_valid !== 1'b1 || m_data !== 8'h39) begin
         bad++;
         $display("FAIL basic_latency: got m_valid=%b m_data=%h want 1/39", m_valid, m_data);
      end
      total++;
      if (frame_err !== 1'b0) begin
         bad++;
         $display("FAIL basic_no_err: got frame_err=%b want 0", frame_err);
      end
      step();
      total++;
      if (m_valid !== 1'b0 || out_q.size() != 1) begin
         bad++;
         $display("FAIL basic_drain: got m_valid=%b frames=%0d want 0/1", m_valid, out_q.size());
      end
   endtask

   task automatic test_back_to_back();
      int st0;
      m_ready = 1'b1;
      out_q.delete();
      out_t.delete();
      st0 = stall;
      send_frame(8'h39);
      send_frame(8'hE4);
      idle();
      step();
      total++;
      if (out_q.size() != 2 || out_q[0] !== 8'h39 || out_q[1] !== 8'hE4) begin
         bad++;
         $display("FAIL b2b_data: got %0d frames want 2 (39,E4)", out_q.size());
      end
      total++;
      if (out_t.size() != 2 || out_t[1] - out_t[0] != FRAME_BEATS) begin
         bad++;
         $display("FAIL b2b_spacing: got %0d frames want spacing %0d", out_t.size(), FRAME_BEATS);
      end
      total++;
      if (stall != st0) begin
         bad++;
         $display("FAIL b2b_ready_drop: got %0d stall cycles want 0", stall - st0);
      end
   endtask

   task automatic test_backpressure();
      bit held_ok = 1;
      m_ready = 1'b0;
      out_q.delete();
      send_frame(8'h1B);
      idle();
      send_frame(8'hE4);
      idle();
      total++;
      if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'h1B) begin
         bad++;
         $display("FAIL bp_wait: got s_ready=%b m_valid=%b m_data=%h want 0/1/1B", s_ready, m_valid, m_data);
      end
      repeat (5) begin
         step();
         if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'h1B) held_ok = 0;
      end
      total++;
      if (!held_ok) begin
         bad++;
         $display("FAIL bp_stable: got s_ready=%b m_valid=%b m_data=%h want 0/1/1B throughout", s_ready, m_valid, m_data);
      end
      m_ready = 1'b1;
      step();
      total++;
      if (m_valid !== 1'b1 || m_data !== 8'hE4 || s_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_release: got m_valid=%b m_data=%h s_ready=%b want 1/E4/1", m_valid, m_data, s_ready);
      end
      step();
      total++;
      if (m_valid !== 1'b0 || out_q.size() != 2 || out_q[0] !== 8'h1B || out_q[1] !== 8'hE4) begin
         bad++;
         $display("FAIL bp_order: got m_valid=%b frames=%0d want 0 and (1B,E4)", m_valid, out_q.size());
      end
   endtask

   task automatic test_short_frame();
      int e0;
      m_ready = 1'b1;
      out_q.delete();
      e0 = n_err;
      send_beat(2'b00, 1'b0);
      send_beat(2'b01, 1'b1);
      idle();
      total++;
      if (frame_err !== 1'b1) begin
         bad++;
         $display("FAIL short_pulse: got frame_err=%b want 1", frame_err);
      end
      step();
      total++;
      if (frame_err !== 1'b0 || m_valid !== 1'b0) begin
         bad++;
         $display("FAIL short_after: got frame_err=%b m_valid=%b want 0/0", frame_err, m_valid);
      end
      send_frame(8'hE4);
      idle();
      step();
      total++;
      if (out_q.size() != 1 || out_q[0] !== 8'hE4 || n_err - e0 != 1) begin
         bad++;
         $display("FAIL short_recover: got frames=%0d errs=%0d want 1 frame E4, 1 err", out_q.size(), n_err - e0);
      end
   endtask

   task automatic test_long_frame();
      int e0;
      logic [IN_BITS-1:0] beats [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
      do_reset();
      m_ready = 1'b1;
      out_q.delete();
      e0 = n_err;
      for (int k = 0; k < 6; k++) send_beat(beats[k], k == 5);
      idle();
      step();
      step();
      total++;
      if (n_err - e0 != 1 || out_q.size() != 0) begin
         bad++;
         $display("FAIL long_discard: got errs=%0d frames=%0d want 1/0", n_err - e0, out_q.size());
      end
      total++;
      if (err_cnt !== EXP_ERRCNT) begin
         bad++;
         $display("FAIL long_err_cnt: got %0d want %0d", err_cnt, EXP_ERRCNT);
      end
      send_frame(8'h39);
      idle();
      step();
      total++;
      if (out_q.size() != 1 || out_q[0] !== 8'h39) begin
         bad++;
         $display("FAIL long_recover: got frames=%0d want 1 frame 39", out_q.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      int e0;
      m_ready = 1'b0;
      out_q.delete();
      send_frame(8'h39);
      idle();
      send_beat(2'b10, 1'b0);
      send_beat(2'b01, 1'b0);
      idle();
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({s_ready, m_valid, m_data, frame_err, err_cnt} !== '0) begin
         bad++;
         $display("FAIL midreset_async: got s_ready=%b m_valid=%b m_data=%h frame_err=%b err_cnt=%h want all 0",
                  s_ready, m_valid, m_data, frame_err, err_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      e0 = n_err;
      m_ready = 1'b1;
      send_frame(8'hE4);
      idle();
      step();
      total++;
      if (out_q.size() != 1 || out_q[0] !== 8'hE4 || n_err != e0) begin
         bad++;
         $display("FAIL midreset_recover: got frames=%0d errs=%0d want 1 frame E4, 0 errs", out_q.size(), n_err - e0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_short_frame();
      test_long_frame();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_layer0_input_framer

// File: doc/layer0_input_framer.md
LAYER0_INPUT_FRAMER -- requirements
Module: layer0_input_framer

Interface
REQ-001 Parameter IN_BITS, default 2, width of one quantized input feature per stream beat.
REQ-002 Parameter FRAME_BEATS, default 32, beats per complete layer-0 input vector; FRAME_W = IN_BITS*FRAME_BEATS.
REQ-003 clk  input  1  single clock, all state rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 s_valid  input  1  upstream beat valid.
REQ-006 s_ready  output  1  framer accepts beat this cycle.
REQ-007 s_data  input  IN_BITS  quantized feature.
REQ-008 s_last  input  1  marks final beat of a frame.
REQ-009 m_valid  output  1  assembled vector valid to layer-0 neuron array.
REQ-010 m_ready  input  1  downstream accepts vector.
REQ-011 m_data  output  FRAME_W  assembled input vector.
REQ-012 frame_err  output  1  one-cycle pulse on malformed frame.
REQ-013 err_cnt  output  16  malformed-frame count (see Configuration).

Function
REQ-014 Beat accepted iff s_valid && s_ready; beat k of a frame (k from 0) SHALL land in m_data[k*IN_BITS +: IN_BITS].
REQ-015 FSM states FILL, WAIT, DISCARD; beat counter 0..FRAME_BEATS-1.
REQ-016 FILL: s_ready=1; each accepted beat increments counter.
REQ-017 FILL, accept at counter==FRAME_BEATS-1 with s_last=1: frame complete; counter->0; moved to output register if it is empty or drained this cycle, else go to WAIT.
REQ-018 FILL, accept with s_last=1 and counter<FRAME_BEATS-1 (short frame): discard partial, counter->0, frame_err pulse next cycle, stay in FILL.
REQ-019 FILL, accept at counter==FRAME_BEATS-1 with s_last=0 (long frame): discard, frame_err pulse, go to DISCARD.
REQ-020 DISCARD: s_ready=1, beats dropped; accepted beat with s_last=1 returns to FILL with counter=0.
REQ-021 WAIT: s_ready=0; when output register frees (m_valid=0 or m_ready=1), transfer frame, return to FILL.
REQ-022 Latency: m_valid SHALL rise the cycle after the last beat is accepted; with m_ready held 1, back-to-back frames SHALL flow with zero bubble cycles.
REQ-023 m_data and m_valid SHALL stay stable while m_valid && !m_ready.
REQ-024 m_valid deasserts the cycle after m_valid && m_ready unless a new frame transfers the same cycle.
REQ-025 FRAME_BEATS=1: every accepted beat is a complete frame if s_last=1, long-frame error otherwise.

Reset
REQ-026 rst_n low SHALL immediately force: state FILL, counter 0, m_valid 0, m_data 0, frame_err 0, err_cnt 0, s_ready 0.
REQ-027 s_ready SHALL rise the first clk edge after rst_n deasserts; a frame in progress at reset is lost without frame_err.

Configuration
REQ-028 Macro LAYER0_FRAMER_ERRCNT_EN defined: err_cnt SHALL increment (saturating at 16'hFFFF) on each frame_err pulse.
REQ-029 Macro undefined: counter logic omitted, err_cnt tied to 0; frame_err unaffected.

Structure
REQ-030 Package layer0_framer_pkg SHALL hold the FSM state typedef and default IN_BITS/FRAME_BEATS constants.
REQ-031 Output register SHALL be a sub-module frame_hold_reg (single-entry valid/ready register, width FRAME_W).

Verification (bench parameters IN_BITS=2, FRAME_BEATS=4)
REQ-032 Beats 01,10,11,00 with s_last on 4th, m_ready=1 -> m_valid one cycle after 4th beat, m_data=8'h39, frame_err=0.
REQ-033 Two frames back-to-back, m_ready=1 -> m_valid high two consecutive frame periods, no s_ready drop.
REQ-034 m_ready=0 for 10 cycles with second complete frame arriving -> first m_data held, s_ready=0 in WAIT, second frame emitted after m_ready rises.
REQ-035 s_last on 2nd beat -> frame_err pulse, no m_valid; next good frame 8'hE4 (beats 00,01,10,11) delivered correctly.
REQ-036 6-beat frame with s_last on 6th -> one frame_err, no m_valid, err_cnt=1 with macro, 0 without.
REQ-037 rst_n low mid-frame after 2 beats -> all outputs zero asynchronously; following full frame delivered intact.
